// File: rtl/spi_peripheral_if.sv
// ============================================================================
// Module   : spi_peripheral_if
// Purpose  : SPI pin bundle between an SPI controller (master) and the
//            register peripheral (slave).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_peripheral_if;
    logic ncs;
    logic sclk;
    logic copi;
    logic cipo;

    modport master (output ncs, output sclk, output copi, input cipo);
    modport slave  (input ncs, input sclk, input copi, output cipo);
endinterface

`default_nettype wire

// File: rtl/spi_peripheral.sv
// ============================================================================
// Module   : spi_peripheral
// Purpose  : Mode-0 SPI slave writing five 8-bit control registers from
//            16-bit frames; optional readback enabled by SPI_READBACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_peripheral #(
    parameter int MAX_ADDR = 4
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    spi_peripheral_if.slave spi,
    output logic [7:0]      en_reg_out_7_0,
    output logic [7:0]      en_reg_out_15_8,
    output logic [7:0]      en_reg_pwm_7_0,
    output logic [7:0]      en_reg_pwm_15_8,
    output logic [7:0]      pwm_duty_cycle
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam int         c_NUM_REGS  = 5;
    localparam logic [6:0] c_MAX_ADDR  = 7'(MAX_ADDR);
    localparam logic [6:0] c_LAST_REG  = 7'(c_NUM_REGS - 1);
    localparam logic [4:0] c_CNT_FULL  = 5'd16;
    localparam logic [4:0] c_CNT_SAT   = 5'd17;

    logic [2:0]  ncs_sync_q;
    logic [2:0]  sclk_sync_q;
    logic [1:0]  copi_sync_q;
    state_t      state_q, state_d;
    logic [15:0] shift_q, shift_d;
    logic [4:0]  count_q, count_d;
    logic [c_NUM_REGS-1:0][7:0] regs_q, regs_d;

    logic w_ncs_fall, w_ncs_rise, w_sclk_rise, w_sclk_fall, w_active;
    logic w_wr_ok;

    assign w_ncs_fall  = ~ncs_sync_q[1] &  ncs_sync_q[2];
    assign w_ncs_rise  =  ncs_sync_q[1] & ~ncs_sync_q[2];
    assign w_sclk_rise =  sclk_sync_q[1] & ~sclk_sync_q[2];
    assign w_sclk_fall = ~sclk_sync_q[1] &  sclk_sync_q[2];
    assign w_active    = ~ncs_sync_q[1];

    // A frame is valid only with exactly 16 bits, the write flag and an in-range address
    assign w_wr_ok = (count_q == c_CNT_FULL) && shift_q[15] &&
                     (shift_q[14:8] <= c_MAX_ADDR) && (shift_q[14:8] <= c_LAST_REG);

`ifdef SPI_READBACK_EN
    logic [7:0] rd_q, rd_d;
    logic       cipo_q, cipo_d;
    logic [6:0] w_rd_addr;
    logic [7:0] w_rd_data;

    // Address bits are complete on the 8th rising edge: six in the shifter plus the live copi bit
    assign w_rd_addr = {shift_q[5:0], copi_sync_q[1]};

    always_comb begin
        w_rd_data = 8'h00;
        for (int k = 0; k < c_NUM_REGS; k++) begin
            if ((w_rd_addr == 7'(k)) && (w_rd_addr <= c_MAX_ADDR)) begin
                w_rd_data = regs_q[k];
            end
        end
    end

    assign spi.cipo = cipo_q & ~spi.ncs;
`else
    assign spi.cipo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ncs_sync_q  <= 3'b000;
            sclk_sync_q <= 3'b000;
            copi_sync_q <= 2'b00;
            state_q     <= ST_IDLE;
            shift_q     <= 16'h0000;
            count_q     <= 5'd0;
            regs_q      <= '0;
`ifdef SPI_READBACK_EN
            rd_q        <= 8'h00;
            cipo_q      <= 1'b0;
`endif
        end else begin
            ncs_sync_q  <= {ncs_sync_q[1:0], spi.ncs};
            sclk_sync_q <= {sclk_sync_q[1:0], spi.sclk};
            copi_sync_q <= {copi_sync_q[0], spi.copi};
            state_q     <= state_d;
            shift_q     <= shift_d;
            count_q     <= count_d;
            regs_q      <= regs_d;
`ifdef SPI_READBACK_EN
            rd_q        <= rd_d;
            cipo_q      <= cipo_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        count_d = count_q;
        regs_d  = regs_q;
`ifdef SPI_READBACK_EN
        rd_d    = rd_q;
        cipo_d  = cipo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_ncs_fall) begin
                    state_d = ST_SHIFT;
                    shift_d = 16'h0000;
                    count_d = 5'd0;
`ifdef SPI_READBACK_EN
                    rd_d    = 8'h00;
                    cipo_d  = 1'b0;
`endif
                end
            end
            ST_SHIFT: begin
                if (w_ncs_rise) begin
                    state_d = ST_COMMIT;
                end else if (w_sclk_rise && w_active) begin
                    shift_d = {shift_q[14:0], copi_sync_q[1]};
                    count_d = (count_q == c_CNT_SAT) ? c_CNT_SAT : count_q + 5'd1;
`ifdef SPI_READBACK_EN
                    if ((count_q == 5'd7) && !shift_q[6]) begin
                        rd_d = w_rd_data;
                    end
`endif
                end
`ifdef SPI_READBACK_EN
                else if (w_sclk_fall && w_active) begin
                    cipo_d = rd_q[7];
                    rd_d   = {rd_q[6:0], 1'b0};
                end
`endif
            end
            ST_COMMIT: begin
                if (w_wr_ok) begin
                    for (int k = 0; k < c_NUM_REGS; k++) begin
                        if (shift_q[14:8] == 7'(k)) begin
                            regs_d[k] = shift_q[7:0];
                        end
                    end
                end
`ifdef SPI_READBACK_EN
                rd_d   = 8'h00;
                cipo_d = 1'b0;
`endif
                // A new frame starting during commit begins from a cleared shifter
                if (w_ncs_fall) begin
                    state_d = ST_SHIFT;
                    shift_d = 16'h0000;
                    count_d = 5'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = regs_q[4];

endmodule

`default_nettype wire

// File: tb/tb_spi_peripheral.sv
// ============================================================================
// Module   : tb_spi_peripheral
// Purpose  : Directed self-checking bench for spi_peripheral (SPI_READBACK_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_peripheral;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    spi_peripheral_if spi_bus ();

    logic [7:0] r0, r1, r2, r3, r4;
    logic [7:0] regs_w [5];
    logic [7:0] exp_regs [5];
    logic [15:0] rx;
    int tests = 0;
    int fails = 0;

    assign regs_w[0] = r0;
    assign regs_w[1] = r1;
    assign regs_w[2] = r2;
    assign regs_w[3] = r3;
    assign regs_w[4] = r4;

    spi_peripheral #(.MAX_ADDR(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .spi             (spi_bus.slave),
        .en_reg_out_7_0  (r0),
        .en_reg_out_15_8 (r1),
        .en_reg_pwm_7_0  (r2),
        .en_reg_pwm_15_8 (r3),
        .pwm_duty_cycle  (r4)
    );

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Lowers ncs and clocks out nbits of word MSB first; ncs is left low
    task automatic spi_shift(input logic [31:0] word, input int nbits, output logic [15:0] rxd);
        rxd = 16'h0000;
        spi_bus.ncs = 1'b0;
        wait_clk(4);
        for (int i = 0; i < nbits; i++) begin
            spi_bus.copi = word[nbits-1-i];
            wait_clk(4);
            spi_bus.sclk = 1'b1;
            rxd = {rxd[14:0], spi_bus.cipo};
            wait_clk(4);
            spi_bus.sclk = 1'b0;
        end
        wait_clk(4);
    endtask

    // Raises ncs and waits the 4-clk update window
    task automatic end_frame();
        spi_bus.ncs  = 1'b1;
        spi_bus.copi = 1'b0;
        wait_clk(4);
    endtask

    task automatic test_reset();
        wait_clk(1);
        rst_n = 1'b0;
        wait_clk(5);
        for (int k = 0; k < 5; k++) begin
            exp_regs[k] = 8'h00;
            tests++;
            if (regs_w[k] !== 8'h00) begin
                $display("FAIL reset_reg%0d: got %h expected 00", k, regs_w[k]);
                fails++;
            end
        end
        tests++;
        if (spi_bus.cipo !== 1'b0) begin
            $display("FAIL reset_cipo: got %b expected 0", spi_bus.cipo);
            fails++;
        end
        rst_n = 1'b1;
        wait_clk(4);
    endtask

    task automatic test_write();
        spi_shift(32'h8480, 16, rx);
        end_frame();
        exp_regs[4] = 8'h80;
        tests++;
        if (r4 !== 8'h80) begin
            $display("FAIL write_pwm_latency: got %h expected 80", r4);
            fails++;
        end
        wait_clk(4);
        spi_shift(32'h80F0, 16, rx);
        end_frame();
        exp_regs[0] = 8'hF0;
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (regs_w[k] !== exp_regs[k]) begin
                $display("FAIL write_reg%0d: got %h expected %h", k, regs_w[k], exp_regs[k]);
                fails++;
            end
        end
        tests++;
        if (spi_bus.cipo !== 1'b0) begin
            $display("FAIL cipo_idle: got %b expected 0", spi_bus.cipo);
            fails++;
        end
        wait_clk(4);
    endtask

    task automatic test_abort();
        spi_shift(32'h81AA >> 6, 10, rx);
        end_frame();
        wait_clk(4);
        tests++;
        if (r1 !== 8'h00) begin
            $display("FAIL abort_reg1: got %h expected 00", r1);
            fails++;
        end
    endtask

    task automatic test_overlong_badaddr();
        spi_shift({15'h0, 16'h82CC, 1'b0}, 17, rx);
        end_frame();
        wait_clk(4);
        tests++;
        if (r2 !== 8'h00) begin
            $display("FAIL overlong_reg2: got %h expected 00", r2);
            fails++;
        end
        spi_shift(32'h8555, 16, rx);
        end_frame();
        wait_clk(4);
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (regs_w[k] !== exp_regs[k]) begin
                $display("FAIL badaddr_reg%0d: got %h expected %h", k, regs_w[k], exp_regs[k]);
                fails++;
            end
        end
    endtask

    task automatic test_back_to_back();
        spi_shift(32'h820F, 16, rx);
        spi_bus.ncs = 1'b1;
        wait_clk(1);
        spi_shift(32'h83F0, 16, rx);
        end_frame();
        exp_regs[2] = 8'h0F;
        exp_regs[3] = 8'hF0;
        tests++;
        if (r2 !== 8'h0F) begin
            $display("FAIL b2b_reg2: got %h expected 0F", r2);
            fails++;
        end
        tests++;
        if (r3 !== 8'hF0) begin
            $display("FAIL b2b_reg3: got %h expected F0", r3);
            fails++;
        end
        wait_clk(4);
    endtask

    task automatic test_readback();
        logic [15:0] exp_rx;
        spi_shift(32'h84A5, 16, rx);
        end_frame();
        exp_regs[4] = 8'hA5;
        wait_clk(4);
        spi_shift(32'h0400, 16, rx);
        end_frame();
`ifdef SPI_READBACK_EN
        exp_rx = 16'h00A5;
`else
        exp_rx = 16'h0000;
`endif
        tests++;
        if (rx !== exp_rx) begin
            $display("FAIL readback_cipo: got %h expected %h", rx, exp_rx);
            fails++;
        end
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (regs_w[k] !== exp_regs[k]) begin
                $display("FAIL read_nowrite_reg%0d: got %h expected %h", k, regs_w[k], exp_regs[k]);
                fails++;
            end
        end
        wait_clk(4);
    endtask

    task automatic test_reset_midframe();
        spi_shift(32'h81, 8, rx);
        rst_n = 1'b0;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(2);
        spi_shift(32'h3C, 8, rx);
        end_frame();
        wait_clk(4);
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (regs_w[k] !== 8'h00) begin
                $display("FAIL midreset_reg%0d: got %h expected 00", k, regs_w[k]);
                fails++;
            end
        end
    endtask

    initial begin
        spi_bus.ncs  = 1'b1;
        spi_bus.sclk = 1'b0;
        spi_bus.copi = 1'b0;
        test_reset();
        test_write();
        test_abort();
        test_overlong_badaddr();
        test_back_to_back();
        test_readback();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_peripheral.md
SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 SHALL have parameter MAX_ADDR, default 4: highest writable register address; higher addresses are ignored.
REQ-002 SHALL have port clk, input, 1: single system clock; all state is in this domain.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port ncs, input, 1: SPI chip select, active-low, asynchronous to clk.
REQ-005 SHALL have port sclk, input, 1: SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-006 SHALL have port copi, input, 1: SPI serial data in, MSB first.
REQ-007 SHALL have port cipo, output, 1: SPI serial data out.
REQ-008 SHALL have port en_reg_out_7_0, output, 8: register 0x00.
REQ-009 SHALL have port en_reg_out_15_8, output, 8: register 0x01.
REQ-010 SHALL have port en_reg_pwm_7_0, output, 8: register 0x02.
REQ-011 SHALL have port en_reg_pwm_15_8, output, 8: register 0x03.
REQ-012 SHALL have port pwm_duty_cycle, output, 8: register 0x04.

Function
REQ-013 SHALL pass ncs, sclk and copi through 2-flop synchronizers, plus one extra stage for edge detection.
REQ-014 SHALL detect an sclk rising/falling edge and an ncs falling/rising edge from synchronized stage 2 vs stage 3.
REQ-015 SHALL use frame format: bit15 = R/W (1 = write), bits14:8 = 7-bit address, bits7:0 = data, MSB first.
REQ-016 SHALL sample copi on each sclk rising edge while synchronized ncs is low; sclk edges while ncs is high are ignored.
REQ-017 SHALL implement FSM IDLE -> SHIFT on ncs fall; SHIFT -> COMMIT on ncs rise; COMMIT -> IDLE after one clk.
REQ-018 SHALL clear the shift register and 5-bit bit counter on every ncs falling edge.
REQ-019 SHALL saturate the bit counter at 17.
REQ-020 SHALL, in COMMIT, write data to the addressed register only if count == 16, R/W = 1 and address <= MAX_ADDR; otherwise discard the frame.
REQ-021 SHALL update a register output no later than 4 clk cycles after the ncs pin rises; all other registers remain unchanged.
REQ-022 SHALL discard a frame aborted mid-stream (ncs rising with count < 16) with no register change.
REQ-023 SHALL, on ncs falling while in COMMIT, complete the commit first and then enter SHIFT with the counter cleared.
REQ-024 SHALL support sclk frequency up to clk/8; faster sclk is unsupported.
REQ-025 SHALL hold cipo at 0 whenever ncs is high.

Reset
REQ-026 SHALL, while rst_n = 0, force all five register outputs to 8'h00, cipo to 0, the FSM to IDLE, and the counter, shift register and synchronizers to 0.
REQ-027 SHALL, on reset asserted mid-frame, discard the frame; after release, await a fresh ncs falling edge.

Configuration
REQ-028 SHALL support readback when macro SPI_READBACK_EN is defined.
REQ-029 With SPI_READBACK_EN defined, a frame with R/W = 0 SHALL, after the 8th sclk rising edge, load the addressed register (00 if address > MAX_ADDR) into a read shifter.
REQ-030 With SPI_READBACK_EN defined, cipo SHALL present read data MSB first, changing on synchronized sclk falling edges.
REQ-031 With SPI_READBACK_EN defined, read frames SHALL never modify registers.
REQ-032 Without SPI_READBACK_EN, cipo SHALL be constant 0, no read shifter SHALL exist, and R/W = 0 frames SHALL be discarded.

Verification
REQ-033 Reset check: rst_n low for 5 clk -> all registers 00, cipo 0.
REQ-034 Write sequence: write 0x80,0x04,0x80 then 0x80,0x00,0xF0 -> pwm_duty_cycle = 80 and en_reg_out_7_0 = F0 within 4 clk of ncs rise; other registers 00.
REQ-035 Aborted frame: ncs rises after 10 bits of 0x80,0x01,0xAA -> en_reg_out_15_8 stays 00.
REQ-036 Overlong frame and bad address: 17-bit frame, and frame 0x80,0x05,0x55 -> no register changes.
REQ-037 Back-to-back frames: two frames with 1-clk ncs-high gap (writes 0x02 = 0x0F, then 0x03 = 0xF0) -> both registers updated.
REQ-038 Readback: with SPI_READBACK_EN, write 0x04 = 0xA5 then read 0x00,0x04 -> cipo shifts out 10100101; without the macro, cipo stays 0.
